// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: RV32 alu_op decode plus iterative RV32M multiply/divide unit with stall/done handshake.
// Define MDU_DIV_EN to build the divider (DIV/DIVU/REM/REMU); otherwise only the MUL* ops are decoded.
`timescale 1ns/1ps
module alu_ctrl_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [16:0]     part_of_inst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [3:0]      alu_op,
  output logic            mdu_sel,
  output logic            stall,
  output logic [XLEN-1:0] mdu_result,
  output logic            mdu_done
);
  localparam logic [6:0] OP_ARITH = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [3:0] FUNC_ADD = 4'd0;
  localparam logic [3:0] FUNC_SUB = 4'd1;
  localparam logic [3:0] FUNC_SLL = 4'd2;
  localparam logic [3:0] FUNC_SRL = 4'd3;
  localparam logic [3:0] FUNC_SRA = 4'd4;
  localparam logic [3:0] FUNC_XOR = 4'd5;
  localparam logic [3:0] FUNC_OR  = 4'd6;
  localparam logic [3:0] FUNC_AND = 4'd7;
  localparam logic [3:0] FUNC_BEQ = 4'd8;
  localparam logic [3:0] FUNC_BNE = 4'd9;
  localparam logic [3:0] FUNC_BLT = 4'd10;
  localparam logic [3:0] FUNC_BGE = 4'd11;
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  logic [6:0] f7, opc;
  logic [2:0] f3;
  logic       m_op;
  assign f7   = part_of_inst[16:10];
  assign f3   = part_of_inst[9:7];
  assign opc  = part_of_inst[6:0];
  assign m_op = (opc == OP_ARITH) && (f7 == 7'b0000001);

`ifdef MDU_DIV_EN
  assign mdu_sel = m_op;
`else
  assign mdu_sel = m_op & ~f3[2];
`endif

  always_comb begin
    alu_op = FUNC_ADD;
    if (opc == OP_ARITH && !m_op)
      case (f3)
        3'd0:    alu_op = f7[5] ? FUNC_SUB : FUNC_ADD;
        3'd4:    alu_op = FUNC_XOR;
        3'd5:    alu_op = f7[5] ? FUNC_SRA : FUNC_SRL;
        3'd6:    alu_op = FUNC_OR;
        3'd7:    alu_op = FUNC_AND;
        default: alu_op = FUNC_ADD;
      endcase
    else if (opc == OP_IMM)
      case (f3)
        3'd1:    alu_op = FUNC_SLL;
        3'd4:    alu_op = FUNC_XOR;
        3'd5:    alu_op = f7[5] ? FUNC_SRA : FUNC_SRL;
        3'd6:    alu_op = FUNC_OR;
        3'd7:    alu_op = FUNC_AND;
        default: alu_op = FUNC_ADD;
      endcase
    else if (opc == OP_BR)
      case (f3)
        3'd0:    alu_op = FUNC_BEQ;
        3'd1:    alu_op = FUNC_BNE;
        3'd4:    alu_op = FUNC_BLT;
        3'd5:    alu_op = FUNC_BGE;
        default: alu_op = FUNC_ADD;
      endcase
  end

  // Signed A: MULH, MULHSU, DIV, REM. Signed B: MULH, DIV, REM.
  logic            sa, sb, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, ld_m, ld_p;
  assign sa    = (f3 == 3'd1) | (f3 == 3'd2) | (f3[2] & ~f3[0]);
  assign sb    = (f3 == 3'd1) | (f3[2] & ~f3[0]);
  assign a_neg = sa & rs1_data[XLEN-1];
  assign b_neg = sb & rs2_data[XLEN-1];
  assign a_mag = a_neg ? -rs1_data : rs1_data;
  assign b_mag = b_neg ? -rs2_data : rs2_data;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              an_q, an_d, bn_q, bn_d;
  logic [XLEN-1:0]   m_q, m_d, res_q, res_d, mul_res, fin;
  logic [2*XLEN-1:0] p_q, p_d, prod, mul_step, step;
  logic [XLEN:0]     sum;

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  assign sum      = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, m_q} : '0);
  assign mul_step = {sum, p_q[XLEN-1:1]};
  assign prod     = (an_q ^ bn_q) ? -p_q : p_q;
  assign mul_res  = (op_q == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

`ifdef MDU_DIV_EN
  logic            dv_q, dv_d, dz;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] quo, rem, q_res, r_res;
  // Restoring divide: {remainder, quotient} shifts left, quotient bit enters at LSB.
  assign diff  = p_q[2*XLEN-1:XLEN-1] - {1'b0, m_q};
  assign step  = dv_q ? {diff[XLEN] ? p_q[2*XLEN-2:XLEN-1] : diff[XLEN-1:0], p_q[XLEN-2:0], ~diff[XLEN]} : mul_step;
  assign quo   = p_q[XLEN-1:0];
  assign rem   = p_q[2*XLEN-1:XLEN];
  assign dz    = (m_q == '0);
  assign q_res = dz ? '1 : ((an_q ^ bn_q) ? -quo : quo);
  assign r_res = an_q ? -rem : rem;
  assign fin   = dv_q ? (op_q[1] ? r_res : q_res) : mul_res;
  assign ld_m  = f3[2] ? b_mag : a_mag;
  assign ld_p  = f3[2] ? a_mag : b_mag;
`else
  assign step  = mul_step;
  assign fin   = mul_res;
  assign ld_m  = a_mag;
  assign ld_p  = b_mag;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    an_d    = an_q;
    bn_d    = bn_q;
    m_d     = m_q;
    p_d     = p_q;
    res_d   = res_q;
`ifdef MDU_DIV_EN
    dv_d    = dv_q;
`endif
    case (state_q)
      IDLE: if (in_valid && mdu_sel) begin
        state_d = BUSY;
        cnt_d   = CW'(XLEN);
        op_d    = f3[1:0];
        an_d    = a_neg;
        bn_d    = b_neg;
        m_d     = ld_m;
        p_d     = {{XLEN{1'b0}}, ld_p};
`ifdef MDU_DIV_EN
        dv_d    = f3[2];
`endif
      end
      BUSY: begin
        p_d     = step;
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? DONE : BUSY;
      end
      DONE: begin
        res_d   = fin;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      an_q    <= 1'b0;
      bn_q    <= 1'b0;
      m_q     <= '0;
      p_q     <= '0;
      res_q   <= '0;
`ifdef MDU_DIV_EN
      dv_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      an_q    <= an_d;
      bn_q    <= bn_d;
      m_q     <= m_d;
      p_q     <= p_d;
      res_q   <= res_d;
`ifdef MDU_DIV_EN
      dv_q    <= dv_d;
`endif
    end
  end

  assign stall      = ~reset & (((state_q == IDLE) & in_valid & mdu_sel) | (state_q == BUSY));
  assign mdu_done   = ~reset & (state_q == DONE);
  assign mdu_result = mdu_done ? fin : res_q;
endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// tb_alu_ctrl_mdu: decode vector table, directed M-op sequences and random M ops against a 64-bit arithmetic model.
`timescale 1ns/1ps
module tb_alu_ctrl_mdu;
  localparam int XLEN = 32;
  localparam logic [3:0] FUNC_ADD = 4'd0, FUNC_SUB = 4'd1, FUNC_SLL = 4'd2, FUNC_SRL = 4'd3,
                         FUNC_SRA = 4'd4, FUNC_XOR = 4'd5, FUNC_OR = 4'd6, FUNC_AND = 4'd7,
                         FUNC_BEQ = 4'd8, FUNC_BNE = 4'd9, FUNC_BLT = 4'd10, FUNC_BGE = 4'd11;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, in_valid, mdu_sel, stall, mdu_done;
  logic [16:0] part_of_inst;
  logic [31:0] rs1_data, rs2_data, mdu_result;
  logic [3:0]  alu_op;
  int          n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  alu_ctrl_mdu #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .part_of_inst(part_of_inst),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .alu_op(alu_op), .mdu_sel(mdu_sel),
    .stall(stall), .mdu_result(mdu_result), .mdu_done(mdu_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    logic        ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Issue one M op at the next cycle and follow it to mdu_done, scrambling operands while busy.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit hold_chk, input string name);
    logic [31:0] exp;
    int cyc, st;
    exp = model(f3, a, b);
    @(negedge clk);
    in_valid     = 1'b1;
    part_of_inst = {7'b0000001, f3, 7'b0110011};
    rs1_data     = a;
    rs2_data     = b;
    cyc = 0;
    st  = 0;
    #1;
    while (!mdu_done && cyc < 3 * XLEN) begin
      if (stall) st++;
      @(negedge clk);
      #1;
      cyc++;
      rs1_data = $urandom;
      rs2_data = $urandom;
    end
    chk({name, " latency"}, 64'(cyc), 64'(XLEN + 1));
    chk({name, " stall cycles"}, 64'(st), 64'(XLEN + 1));
    chk({name, " stall in done"}, 64'(stall), 64'd0);
    chk({name, " result"}, 64'(mdu_result), 64'(exp));
    in_valid = 1'b0;
    if (hold_chk) begin
      @(negedge clk);
      #1;
      chk({name, " done pulse"}, 64'(mdu_done), 64'd0);
      chk({name, " result hold"}, 64'(mdu_result), 64'(exp));
    end
  endtask

  typedef struct {
    logic [16:0] inst;
    logic [3:0]  op;
    logic        sel;
    string       name;
  } dvec_t;

  initial begin
    dvec_t dv[$];
    int    dn;
    dv.push_back('{{7'h00, 3'd0, 7'h33}, FUNC_ADD, 1'b0, "ADD"});
    dv.push_back('{{7'h20, 3'd0, 7'h33}, FUNC_SUB, 1'b0, "SUB"});
    dv.push_back('{{7'h00, 3'd4, 7'h33}, FUNC_XOR, 1'b0, "XOR"});
    dv.push_back('{{7'h00, 3'd6, 7'h33}, FUNC_OR,  1'b0, "OR"});
    dv.push_back('{{7'h00, 3'd7, 7'h33}, FUNC_AND, 1'b0, "AND"});
    dv.push_back('{{7'h00, 3'd5, 7'h33}, FUNC_SRL, 1'b0, "SRL"});
    dv.push_back('{{7'h20, 3'd5, 7'h33}, FUNC_SRA, 1'b0, "SRA"});
    dv.push_back('{{7'h00, 3'd2, 7'h33}, FUNC_ADD, 1'b0, "SLT"});
    dv.push_back('{{7'h20, 3'd0, 7'h13}, FUNC_ADD, 1'b0, "ADDI"});
    dv.push_back('{{7'h00, 3'd1, 7'h13}, FUNC_SLL, 1'b0, "SLLI"});
    dv.push_back('{{7'h00, 3'd4, 7'h13}, FUNC_XOR, 1'b0, "XORI"});
    dv.push_back('{{7'h00, 3'd6, 7'h13}, FUNC_OR,  1'b0, "ORI"});
    dv.push_back('{{7'h00, 3'd7, 7'h13}, FUNC_AND, 1'b0, "ANDI"});
    dv.push_back('{{7'h00, 3'd5, 7'h13}, FUNC_SRL, 1'b0, "SRLI"});
    dv.push_back('{{7'h20, 3'd5, 7'h13}, FUNC_SRA, 1'b0, "SRAI"});
    dv.push_back('{{7'h00, 3'd0, 7'h63}, FUNC_BEQ, 1'b0, "BEQ"});
    dv.push_back('{{7'h00, 3'd1, 7'h63}, FUNC_BNE, 1'b0, "BNE"});
    dv.push_back('{{7'h00, 3'd4, 7'h63}, FUNC_BLT, 1'b0, "BLT"});
    dv.push_back('{{7'h00, 3'd5, 7'h63}, FUNC_BGE, 1'b0, "BGE"});
    dv.push_back('{{7'h00, 3'd6, 7'h63}, FUNC_ADD, 1'b0, "BLTU"});
    dv.push_back('{{7'h00, 3'd2, 7'h03}, FUNC_ADD, 1'b0, "LW"});
    dv.push_back('{{7'h01, 3'd0, 7'h13}, FUNC_ADD, 1'b0, "ADDI f7=1"});
    dv.push_back('{{7'h01, 3'd0, 7'h33}, FUNC_ADD, 1'b1, "MUL"});
    dv.push_back('{{7'h01, 3'd3, 7'h33}, FUNC_ADD, 1'b1, "MULHU"});
    dv.push_back('{{7'h01, 3'd4, 7'h33}, FUNC_ADD, DIV_EN, "DIV"});
    dv.push_back('{{7'h01, 3'd7, 7'h33}, FUNC_ADD, DIV_EN, "REMU"});

    reset        = 1'b1;
    in_valid     = 1'b0;
    part_of_inst = '0;
    rs1_data     = '0;
    rs2_data     = '0;
    repeat (3) @(negedge clk);
    in_valid     = 1'b1;
    part_of_inst = {7'b0000001, 3'd0, 7'b0110011};
    #1;
    chk("stall forced low in reset", 64'(stall), 64'd0);
    chk("done low in reset", 64'(mdu_done), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    chk("reset stall", 64'(stall), 64'd0);
    chk("reset done", 64'(mdu_done), 64'd0);
    chk("reset result", 64'(mdu_result), 64'd0);

    dn = dv.size();
    for (int i = 0; i < dn; i++) begin
      @(negedge clk);
      part_of_inst = dv[i].inst;
      in_valid     = !dv[i].sel;
      rs1_data     = $urandom;
      rs2_data     = $urandom;
      #1;
      chk({dv[i].name, " alu_op"}, 64'(alu_op), 64'(dv[i].op));
      chk({dv[i].name, " mdu_sel"}, 64'(mdu_sel), 64'(dv[i].sel));
      chk({dv[i].name, " stall"}, 64'(stall), 64'd0);
      chk({dv[i].name, " no done"}, 64'(mdu_done), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, "MUL 7*-3");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, "MULH min*min");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "MULHU max*max");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, "MULHSU -1*2");
    if (DIV_EN) begin
      run_op(3'd5, 32'd100, 32'd7, 1'b1, "DIVU 100/7");
      run_op(3'd7, 32'd100, 32'd7, 1'b0, "REMU 100/7");
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, "DIV -7/2");
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1, "REM -7/2");
      run_op(3'd4, 32'h1234_5678, 32'd0, 1'b1, "DIV x/0");
      run_op(3'd6, 32'h8765_4321, 32'd0, 1'b1, "REM x/0");
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "DIV ovf");
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "REM ovf");
    end

    for (int i = 0; i < 40; i++) begin
      logic [2:0] f3;
      f3 = 3'($urandom_range(0, DIV_EN ? 7 : 3));
      run_op(f3, pick(), pick(), 1'($urandom_range(0, 1)), $sformatf("rand%0d f3=%0d", i, f3));
    end

    run_op(3'd0, 32'd5, 32'd9, 1'b1, "MUL 5*9");
    @(negedge clk);
    in_valid     = 1'b1;
    part_of_inst = {7'b0000001, DIV_EN ? 3'd4 : 3'd1, 7'b0110011};
    rs1_data     = 32'd1000;
    rs2_data     = 32'd3;
    repeat (10) @(negedge clk);
    #1;
    chk("abort stall before reset", 64'(stall), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort stall during reset", 64'(stall), 64'd0);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("abort stall", 64'(stall), 64'd0);
    chk("abort done", 64'(mdu_done), 64'd0);
    chk("abort result cleared", 64'(mdu_result), 64'd0);
    begin
      int pulses = 0;
      repeat (2 * XLEN) begin
        @(negedge clk);
        if (mdu_done || stall) pulses++;
      end
      chk("abort idle afterwards", 64'(pulses), 64'd0);
    end
    run_op(3'd0, 32'hDEAD_BEEF, 32'h0000_0010, 1'b1, "MUL after abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/alu_ctrl_mdu.md
# alu_ctrl_mdu

Next-generation ALU control for the RV32 core. It keeps the combinational `alu_op` decode for base-ISA arithmetic and branch instructions. It adds an iterative multiply/divide unit (MDU) for the RV32M `funct7 = 0000001` encodings, with a stall/done handshake toward the datapath. It is parametrised in operand width and sits between instruction decode and the execute stage.

## Interface
- `XLEN`, 32: operand/result width; must be even and ≥ 8.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  instruction in execute this cycle.
- `part_of_inst`  in  17  `{funct7[16:10], funct3[9:7], opcode[6:0]}`.
- `rs1_data`  in  XLEN  operand A.
- `rs2_data`  in  XLEN  operand B.
- `alu_op`  out  4  `alu_func.v` encoding; combinational.
- `mdu_sel`  out  1  decoded instruction is an enabled M op; combinational.
- `stall`  out  1  hold PC/pipeline; datapath must keep inputs stable while high.
- `mdu_result`  out  XLEN  MDU result, valid when `mdu_done`.
- `mdu_done`  out  1  one-cycle pulse; instruction retires this cycle.

## Operation
- **`alu_op` decode**
  - `ARITHMETIC` with funct7 ≠ 0000001: ADD/SUB (funct7 bit 5), XOR, OR, AND, SRL/SRA.
  - `ARITHMETIC_IMM`: ADD, SLL, XOR, OR, AND, SRL/SRA.
  - `BRANCH`: BEQ/BNE/BLT/BGE.
  - Anything else, including M ops: `FUNC_ADD`.
- **M ops by funct3**
  - 0 MUL: low XLEN of the product.
  - 1 MULH: high XLEN, signed×signed.
  - 2 MULHSU: high XLEN, signed×unsigned.
  - 3 MULHU: high XLEN, unsigned×unsigned.
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- **FSM states**
  - IDLE → BUSY when `in_valid & mdu_sel`. Latch operand magnitudes, sign flags, op and count = XLEN.
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle; decrement count. At count = 1 → DONE.
  - DONE: apply sign correction, assert `mdu_done`, → IDLE.
  - No restart is possible from BUSY or DONE.
- **Arithmetic**
  - Multiply: 2·XLEN-bit unsigned accumulator on magnitudes; two's-complement negate if signs differ.
  - Divide: unsigned quotient/remainder. Quotient is negated if signs differ; remainder takes the dividend's sign.
- **Special cases**, resolved in DONE with the same fixed latency:
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (−2^(XLEN−1) ÷ −1): quotient = −2^(XLEN−1), remainder = 0.
- **Outputs**
  - `stall` = `(IDLE & in_valid & mdu_sel) | BUSY`. Low in DONE and for non-M instructions.
  - `mdu_result` holds its value until the next DONE.

## Timing
- **Reset values**: state IDLE, count 0, `mdu_result` 0, `mdu_done` 0, `stall` 0. `stall` is forced 0 while `reset` is high.
- **Latency**: accept at cycle T; BUSY T+1..T+XLEN; DONE at T+XLEN+1. Total XLEN+2 cycles.
- **Stall window**: `stall` is high T..T+XLEN.
- **Back-to-back M ops**: the next instruction can be accepted at T+XLEN+2, because DONE always returns to IDLE.
- **Input changes**: operand changes during BUSY are ignored; operands are latched at T.
- **Reset mid-operation**: on the next edge, go to IDLE with no `mdu_done`. `mdu_result` is cleared.
- **`in_valid` low in IDLE**: no state change.

## Configuration
- `MDU_DIV_EN` defined: all eight M ops are implemented.
- `MDU_DIV_EN` undefined:
  - Divider datapath is removed.
  - funct3[2] = 1 M ops decode with `mdu_sel` = 0, `alu_op` = `FUNC_ADD`, and never stall. The trap is handled upstream.
  - MUL/MULH/MULHSU/MULHU behave unchanged.

## Test plan
- MUL, A=7, B=0xFFFFFFFD (XLEN=32): `stall` high 33 cycles; at T+33, `mdu_done`=1 and `mdu_result`=0xFFFFFFEB.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIVU 100/7 → 14 and REMU → 2. DIV −7/2 → 0xFFFFFFFD and REM → 0xFFFFFFFF.
- DIV x/0 → 0xFFFFFFFF and REM x/0 → x. DIV 0x80000000/−1 → 0x80000000 and REM → 0. All at the fixed latency.
- `reset` pulsed at T+10 of a DIV: IDLE next cycle, `stall`/`mdu_done`/`mdu_result` = 0. A subsequent MUL completes normally.
- Non-M ADD/SUB/SRA/BLT decode to the correct `alu_op` with `stall`=0. With `MDU_DIV_EN` undefined, DIV gives `mdu_sel`=0 and no stall.
